ps2_key_decoder: RTL and testbench

//  Sequential successor to the combinational scan-code lookup. Consumes set-2 PS/2

---
 rtl/ps2_pkg.sv | 66 ++++++
 rtl/ps2_key_fifo.sv | 63 ++++++
 rtl/ps2_key_decoder.sv | 129 ++++++++++++
 tb/tb_ps2_key_decoder.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// ps2_pkg -- shared definitions for the PS/2 set-2 key decoder.
//   state_t       : decode FSM states (IDLE, BRK, EXT, EXT_BRK)
//   SC_*          : prefix and modifier scan codes
//   ps2_to_ascii  : combinational scan-code lookup, returns {valid, ascii[7:0]}
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BRK     = 2'd1,
    EXT     = 2'd2,
    EXT_BRK = 2'd3
  } state_t;

  localparam logic [7:0] SC_BREAK  = 8'hF0;
  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CAPS   = 8'h58;

  // upper: letters produce uppercase (shift XOR caps-lock).
  // shift: digits produce their shifted symbol (caps-lock does not apply).
  function automatic logic [8:0] ps2_to_ascii(input logic [7:0] code,
                                              input logic       upper,
                                              input logic       shift);
    logic [7:0] lc;
    logic [7:0] ascii;
    logic       is_letter;
    logic       valid;
    lc        = 8'h00;
    ascii     = 8'h00;
    is_letter = 1'b1;
    valid     = 1'b1;
    case (code)
      8'h1C: lc = 8'h61; 8'h32: lc = 8'h62; 8'h21: lc = 8'h63; 8'h23: lc = 8'h64;
      8'h24: lc = 8'h65; 8'h2B: lc = 8'h66; 8'h34: lc = 8'h67; 8'h33: lc = 8'h68;
      8'h43: lc = 8'h69; 8'h3B: lc = 8'h6A; 8'h42: lc = 8'h6B; 8'h4B: lc = 8'h6C;
      8'h3A: lc = 8'h6D; 8'h31: lc = 8'h6E; 8'h44: lc = 8'h6F; 8'h4D: lc = 8'h70;
      8'h15: lc = 8'h71; 8'h2D: lc = 8'h72; 8'h1B: lc = 8'h73; 8'h2C: lc = 8'h74;
      8'h3C: lc = 8'h75; 8'h2A: lc = 8'h76; 8'h1D: lc = 8'h77; 8'h22: lc = 8'h78;
      8'h35: lc = 8'h79; 8'h1A: lc = 8'h7A;
      default: is_letter = 1'b0;
    endcase
    if (is_letter) begin
      ascii = upper ? (lc - 8'h20) : lc;
    end else begin
      case (code)
        8'h45: ascii = shift ? 8'h29 : 8'h30;  // 0 )
        8'h16: ascii = shift ? 8'h21 : 8'h31;  // 1 !
        8'h1E: ascii = shift ? 8'h40 : 8'h32;  // 2 @
        8'h26: ascii = shift ? 8'h23 : 8'h33;  // 3 #
        8'h25: ascii = shift ? 8'h24 : 8'h34;  // 4 $
        8'h2E: ascii = shift ? 8'h25 : 8'h35;  // 5 %
        8'h36: ascii = shift ? 8'h5E : 8'h36;  // 6 ^
        8'h3D: ascii = shift ? 8'h26 : 8'h37;  // 7 &
        8'h3E: ascii = shift ? 8'h2A : 8'h38;  // 8 *
        8'h46: ascii = shift ? 8'h28 : 8'h39;  // 9 (
        8'h29: ascii = 8'h20;                  // space
        8'h5A: ascii = 8'h0D;                  // enter
        8'h66: ascii = 8'h08;                  // backspace
        default: valid = 1'b0;
      endcase
    end
    return {valid, ascii};
  endfunction

endpackage

// File: rtl/ps2_key_fifo.sv
// ps2_key_fifo -- small synchronous ready/valid FIFO for decoded ASCII.
//   clk, rst     : clock, asynchronous active-high reset
//   push, wdata  : write request and data (dropped when full unless popping)
//   pop          : read request (ignored when empty)
//   rdata        : head entry, 0 while empty
//   full, empty  : occupancy flags derived from the registered count
module ps2_key_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  // A full FIFO still accepts a write in the same cycle the head leaves.
  assign do_push = push & (~full | do_pop);
  assign rdata   = empty ? '0 : mem[rd_ptr];

  // NOTE: storage carries no reset; the count gates every read, so stale
  // contents are never observed and the array can map onto plain RAM cells.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // NOTE: all state uses non-blocking assignment so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // Power-of-2 depth: pointers wrap modulo DEPTH by natural overflow.
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder -- set-2 PS/2 scan-code decoder with ASCII output FIFO.
//   clk, rst    : clock, asynchronous active-high reset
//   code_in     : scan-code byte, qualified by the 1-cycle code_valid strobe
//   out_ascii   : FIFO head; out_valid = non-empty; popped on out_valid&out_ready
//   held_code   : last made key not yet released (0 = none)
//   shift_st    : either shift key held;  caps_st : caps-lock latched
//   press_cnt   : ASCII-producing presses, typematic repeats excluded, wraps
//   overflow    : sticky, set when a push is dropped on a full FIFO
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 8,
  parameter bit REPEAT_EN  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       code_in,
  input  logic             code_valid,
  output logic [7:0]       out_ascii,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       held_code,
  output logic             shift_st,
  output logic             caps_st,
  output logic [CNT_W-1:0] press_cnt,
  output logic             overflow
);

  state_t     state;
  logic       lshift;
  logic       rshift;
  logic       caps;
  logic [8:0] lookup;
  logic       is_make;
  logic       is_break;
  logic       is_mod;
  logic       is_repeat;
  logic       count_en;
  logic       fifo_push;
  logic       fifo_full;
  logic       fifo_empty;

  assign shift_st  = lshift | rshift;
  assign caps_st   = caps;
  assign out_valid = ~fifo_empty;

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    is_make  = 1'b0;
    is_break = 1'b0;
    if (code_valid) begin
      case (state)
        IDLE:    is_make  = (code_in != SC_BREAK) && (code_in != SC_EXT);
        BRK:     is_break = 1'b1;
        default: ;
      endcase
    end
    is_mod    = (code_in == SC_LSHIFT) || (code_in == SC_RSHIFT) || (code_in == SC_CAPS);
    is_repeat = (code_in == held_code);
    // Modifier state is registered, so a shift/caps change applies from the next byte.
    lookup    = ps2_to_ascii(code_in, shift_st ^ caps, shift_st);
    count_en  = is_make & ~is_mod & lookup[8] & ~is_repeat;
    fifo_push = is_make & ~is_mod & lookup[8] & (~is_repeat | REPEAT_EN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else if (code_valid) begin
      case (state)
        IDLE: begin
          if (code_in == SC_BREAK)    state <= BRK;
          else if (code_in == SC_EXT) state <= EXT;
        end
        BRK:     state <= IDLE;
        // Extended keys have no ASCII; only their break needs swallowing.
        EXT:     state <= (code_in == SC_BREAK) ? EXT_BRK : IDLE;
        EXT_BRK: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lshift    <= 1'b0;
      rshift    <= 1'b0;
      caps      <= 1'b0;
      held_code <= 8'h00;
      press_cnt <= '0;
      overflow  <= 1'b0;
    end else begin
      if (is_make) begin
        if (code_in == SC_LSHIFT) lshift <= 1'b1;
        if (code_in == SC_RSHIFT) rshift <= 1'b1;
        // Typematic repeats of caps-lock must not keep toggling it.
        if (code_in == SC_CAPS && !is_repeat) caps <= ~caps;
        // Modifiers are tracked as held keys too, so a key re-pressed after
        // a modifier counts as a fresh press rather than a repeat.
        held_code <= code_in;
      end
      if (is_break) begin
        if (code_in == SC_LSHIFT) lshift <= 1'b0;
        if (code_in == SC_RSHIFT) rshift <= 1'b0;
        if (code_in == held_code) held_code <= 8'h00;
      end
      if (count_en) press_cnt <= press_cnt + CNT_W'(1);
      // When full, a pop makes room, so only a push without pop is lost.
      if (fifo_push && fifo_full && !out_ready) overflow <= 1'b1;
    end
  end

  ps2_key_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (8)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .wdata (lookup[7:0]),
    .pop   (out_ready),
    .rdata (out_ascii),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Scoreboard bench: stimulus pushes hand-computed ASCII into a queue, a
// monitor compares the FIFO head on every accepted output beat.
module tb_ps2_key_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] code_in, code_in_r;
  logic       code_valid, code_valid_r;
  logic       out_ready;
  logic       out_ready_r = 1'b1;
  logic [7:0] out_ascii, out_ascii_r;
  logic       out_valid, out_valid_r;
  logic [7:0] held_code, held_code_r;
  logic       shift_st, shift_st_r, caps_st, caps_st_r;
  logic [7:0] press_cnt, press_cnt_r;
  logic       overflow, overflow_r;

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_qr[$];

  always #5 clk = ~clk;

  ps2_key_decoder #(.FIFO_DEPTH(8), .CNT_W(8), .REPEAT_EN(1'b0)) dut (
    .clk(clk), .rst(rst), .code_in(code_in), .code_valid(code_valid),
    .out_ascii(out_ascii), .out_valid(out_valid), .out_ready(out_ready),
    .held_code(held_code), .shift_st(shift_st), .caps_st(caps_st),
    .press_cnt(press_cnt), .overflow(overflow));

  ps2_key_decoder #(.FIFO_DEPTH(8), .CNT_W(8), .REPEAT_EN(1'b1)) dut_rep (
    .clk(clk), .rst(rst), .code_in(code_in_r), .code_valid(code_valid_r),
    .out_ascii(out_ascii_r), .out_valid(out_valid_r), .out_ready(out_ready_r),
    .held_code(held_code_r), .shift_st(shift_st_r), .caps_st(caps_st_r),
    .press_cnt(press_cnt_r), .overflow(overflow_r));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0 && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL unexpected_out: got %0h expected none", out_ascii);
      end else check("fifo_head", out_ascii, exp_q.pop_front());
    end
  end

  always @(negedge clk) begin
    if (rst === 1'b0 && out_valid_r && out_ready_r) begin
      if (exp_qr.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL unexpected_out_rep: got %0h expected none", out_ascii_r);
      end else check("fifo_head_rep", out_ascii_r, exp_qr.pop_front());
    end
  end

  task automatic send(input logic [7:0] b);
    @(posedge clk); #1;
    code_in = b; code_valid = 1'b1;
    @(posedge clk); #1;
    code_valid = 1'b0;
  endtask

  task automatic send_exp(input logic [7:0] b, input logic [7:0] a);
    exp_q.push_back(a);
    send(b);
  endtask

  task automatic send_r(input logic [7:0] b);
    @(posedge clk); #1;
    code_in_r = b; code_valid_r = 1'b1;
    @(posedge clk); #1;
    code_valid_r = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; code_valid = 1'b0; code_valid_r = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Bounded wait for the scoreboard to empty, then confirm nothing extra.
  task automatic drain(input string name);
    for (int i = 0; i < 60 && (exp_q.size() != 0 || exp_qr.size() != 0); i++)
      @(posedge clk);
    check({name, "_pending"}, exp_q.size() + exp_qr.size(), 0);
    exp_q.delete(); exp_qr.delete();
    repeat (2) @(posedge clk); #1;
    check({name, "_empty"}, {out_valid, out_valid_r}, 2'b00);
  endtask

  initial begin
    code_in = 8'h00; code_valid = 1'b0; out_ready = 1'b1;
    code_in_r = 8'h00; code_valid_r = 1'b0;
    repeat (2) @(posedge clk); #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_ascii", out_ascii, 0);
    check("rst_held", held_code, 0);
    check("rst_mods", {shift_st, caps_st}, 0);
    check("rst_cnt", press_cnt, 0);
    check("rst_ovf", overflow, 0);
    check("rst_rep_all", {out_valid_r, held_code_r, press_cnt_r, overflow_r}, 0);
    rst = 1'b0;

    // Make/break of 'a'.
    send_exp(8'h1C, 8'h61);
    check("t1_held_make", held_code, 8'h1C);
    send(8'hF0); send(8'h1C);
    check("t1_held_brk", held_code, 8'h00);
    check("t1_cnt", press_cnt, 1);
    drain("t1");

    // Shifted letter.
    do_reset();
    send(8'h12);
    check("t2_shift_on", shift_st, 1);
    send_exp(8'h1C, 8'h41);
    send(8'hF0); send(8'h1C); send(8'hF0); send(8'h12);
    check("t2_shift_off", shift_st, 0);
    check("t2_cnt", press_cnt, 1);
    drain("t2");

    // Caps-lock affects letters only; shift cancels caps for letters.
    do_reset();
    send(8'h58); send(8'hF0); send(8'h58);
    check("t3_caps", caps_st, 1);
    send_exp(8'h16, 8'h31);
    send(8'h12);
    send_exp(8'h16, 8'h21);
    send_exp(8'h1C, 8'h61);
    check("t3_cnt", press_cnt, 3);
    drain("t3");

    // Typematic repeat: suppressed here, emitted by the REPEAT_EN instance.
    do_reset();
    send_exp(8'h1C, 8'h61); send(8'h1C); send(8'h1C);
    check("t4_cnt", press_cnt, 1);
    repeat (3) exp_qr.push_back(8'h61);
    send_r(8'h1C); send_r(8'h1C); send_r(8'h1C);
    check("t4_cnt_rep", press_cnt_r, 1);
    check("t4_held_rep", held_code_r, 8'h1C);
    drain("t4");

    // Extended make/break leave held key and counters alone.
    do_reset();
    send_exp(8'h1C, 8'h61);
    send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75);
    check("t5_held", held_code, 8'h1C);
    check("t5_cnt", press_cnt, 1);
    drain("t5");

    // Reset between F0 and its code: next byte is a make.
    do_reset();
    send(8'hF0);
    do_reset();
    send_exp(8'h1C, 8'h61);
    check("t6_held", held_code, 8'h1C);
    drain("t6");

    // Fill and overflow with out_ready low, then push+pop while full.
    do_reset();
    out_ready = 1'b0;
    send_exp(8'h1C, 8'h61); send_exp(8'h32, 8'h62); send_exp(8'h21, 8'h63);
    send_exp(8'h23, 8'h64); send_exp(8'h24, 8'h65); send_exp(8'h2B, 8'h66);
    send_exp(8'h34, 8'h67); send_exp(8'h33, 8'h68);
    check("t7_no_ovf_at_8", overflow, 0);
    send(8'h43);
    check("t7_ovf", overflow, 1);
    check("t7_cnt", press_cnt, 9);
    repeat (3) @(posedge clk); #1;
    check("t7_head_stable", {out_valid, out_ascii}, {1'b1, 8'h61});
    exp_q.push_back(8'h6A);
    @(posedge clk); #1;
    out_ready = 1'b1; code_in = 8'h3B; code_valid = 1'b1;
    @(posedge clk); #1;
    code_valid = 1'b0;
    check("t7_ovf_sticky", overflow, 1);
    drain("t7");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
